// File: rtl/shiftx32.sv
// Registered 32-bit barrel shifter (SLL/SRL/SRA) for the datapath.
// A five-stage logarithmic mux network feeds a single output register, giving one cycle of latency.
module shiftx32 (
  input  logic        Clk,
  input  logic        RstN,
  input  logic [31:0] X,
  input  logic [4:0]  Sa,
  input  logic        IsArith,
  input  logic        IsRight,
  output logic [31:0] Y
);

  localparam int W  = 32;
  localparam int SW = 5;

  logic          fillBit;
  logic [W-1:0]  stage [0:SW];

  assign fillBit  = IsRight & IsArith & X[W-1];
  assign stage[0] = X;

  // Stage g shifts by 2**g when Sa[g] is set.
  for (genvar g = 0; g < SW; g++) begin : gStage
    localparam int Step = 2 ** g;
    logic [W-1:0] shifted;
    assign shifted    = IsRight ? {{Step{fillBit}}, stage[g][W-1:Step]}
                                : {stage[g][W-1-Step:0], {Step{1'b0}}};
    assign stage[g+1] = Sa[g] ? shifted : stage[g];
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) Y <= '0;
    else       Y <= stage[SW];
  end

endmodule

// File: tb/tb_shiftx32.sv
// Scoreboard bench for shiftx32: the driver pushes expected results into a queue and
// a monitor pops and compares them one cycle later against Y.
module tb_shiftx32;

  logic        Clk = 1'b0;
  logic        RstN;
  logic [31:0] X;
  logic [4:0]  Sa;
  logic        IsArith;
  logic        IsRight;
  logic [31:0] Y;

  int nTests = 0;
  int nFail  = 0;
  bit monEn  = 1'b0;
  logic [31:0] expQ [$];

  shiftx32 dut (
    .Clk(Clk), .RstN(RstN), .X(X), .Sa(Sa),
    .IsArith(IsArith), .IsRight(IsRight), .Y(Y)
  );

  always #5 Clk = ~Clk;

  // Reference model: shifts expressed as multiplication / division by 2**sa.
  function automatic logic [31:0] model(input logic [31:0] x, input logic [4:0] sa,
                                        input logic ar, input logic rt);
    logic [63:0] prod;
    logic [31:0] pow;
    pow = 32'd1 << sa;
    if (!rt) begin
      prod = {32'd0, x} * {32'd0, pow};
      return prod[31:0];
    end
    if (ar && x[31]) return ~((~x) / pow);
    return x / pow;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] x, input logic [4:0] sa,
                       input logic ar, input logic rt);
    @(negedge Clk);
    X = x; Sa = sa; IsArith = ar; IsRight = rt;
    expQ.push_back(model(x, sa, ar, rt));
  endtask

  task automatic drain();
    int budget = 10;
    while (expQ.size() > 0 && budget > 0) begin
      @(negedge Clk);
      budget--;
    end
    nTests++;
    if (expQ.size() > 0) begin
      nFail++;
      $display("FAIL drain: %0d results still pending, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  always @(posedge Clk) begin
    #1;
    if (monEn && expQ.size() > 0) check("scoreboard", Y, expQ.pop_front());
  end

  initial begin
    RstN = 1'b0; X = 32'hFFFF_FFFF; Sa = 5'd5; IsArith = 1'b0; IsRight = 1'b0;
    #1 check("reset_no_edge", Y, 32'h0);
    @(posedge Clk); #1 check("reset_held", Y, 32'h0);

    @(negedge Clk);
    RstN = 1'b1;
    expQ.push_back(32'hFFFF_FFE0);
    monEn = 1'b1;

    issue(32'h1, 5'd1, 1'b0, 1'b0);
    issue(32'h1, 5'd2, 1'b0, 1'b0);
    issue(32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0);
    issue(32'h8000_0000, 5'd4, 1'b0, 1'b1);
    issue(32'h8000_0000, 5'd4, 1'b1, 1'b1);
    issue(32'h7000_0000, 5'd4, 1'b1, 1'b1);
    for (int m = 0; m < 4; m++) issue(32'hDEAD_BEEF, 5'd0, m[0], m[1]);
    issue(32'h8000_0000, 5'd31, 1'b1, 1'b1);
    issue(32'h8000_0000, 5'd31, 1'b0, 1'b1);
    issue(32'h8000_0001, 5'd1, 1'b1, 1'b0);
    drain();

    // Spot-check the model itself on known constants.
    check("model_sra", model(32'h8000_0000, 5'd4, 1'b1, 1'b1), 32'hF800_0000);
    check("model_sll", model(32'hFFFF_FFFF, 5'd31, 1'b0, 1'b0), 32'h8000_0000);

    for (int i = 0; i < 1200; i++)
      issue($urandom, 5'($urandom_range(31)), 1'($urandom), 1'($urandom));
    drain();

    // Reset asserted mid-operation discards the pending result.
    monEn = 1'b0;
    @(negedge Clk);
    X = 32'h1234_5678; Sa = 5'd3; IsArith = 1'b0; IsRight = 1'b0;
    #2 RstN = 1'b0;
    #1 check("midop_reset", Y, 32'h0);
    @(posedge Clk); #1 check("midop_reset_held", Y, 32'h0);
    @(negedge Clk);
    RstN = 1'b1;
    X = 32'hC000_0003; Sa = 5'd1; IsArith = 1'b1; IsRight = 1'b1;
    expQ.push_back(32'hE000_0001);
    monEn = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
